// File: rtl/traffic_pkg.sv
// Shared light codes and width helper for the traffic phase sequencer.
package traffic_pkg;

    localparam logic [1:0] L_OFF   = 2'd0;
    localparam logic [1:0] L_LEFT  = 2'd1;
    localparam logic [1:0] L_FWD   = 2'd2;
    localparam logic [1:0] L_RIGHT = 2'd3;

    function automatic int unsigned ph_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered 1-bit rising-edge detector; history clears on synchronous reset.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Parametrised intersection phase sequencer with programmable, saturating phase durations.
// Optional pedestrian request clamp enabled by defining TRAFFIC_PED_REQ_EN.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned CNT_W      = 8,
    parameter logic [NUM_PHASES*CNT_W-1:0] DUR_INIT    = {8'd10, 8'd10, 8'd15, 8'd3},
    parameter logic [NUM_PHASES*2-1:0]     LIGHT_A_MAP = {2'd1, 2'd3, 2'd2, 2'd0},
    parameter logic [NUM_PHASES*2-1:0]     LIGHT_B_MAP = {2'd3, 2'd1, 2'd0, 2'd2},
    parameter int unsigned MIN_DUR    = 1,
    parameter int unsigned MAX_DUR    = 2**CNT_W - 1,
    parameter int unsigned PED_CLAMP  = 5,
    localparam int unsigned PH_W      = ph_width(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             halt,
    input  logic             cfg_en,
    input  logic [PH_W-1:0]  cfg_sel,
    input  logic             inc,
    input  logic             dec,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       light_a,
    output logic [1:0]       light_b,
    output logic             phase_done
`ifdef TRAFFIC_PED_REQ_EN
    ,
    input  logic             ped_req,
    output logic             ped_pending
`endif
);

    logic [CNT_W-1:0] dur     [NUM_PHASES];
    logic [CNT_W-1:0] dur_nxt [NUM_PHASES];
    logic [PH_W-1:0]  phase_nxt;
    logic [PH_W-1:0]  phase_succ;
    logic [CNT_W-1:0] remaining_nxt;
    logic             done_nxt;
    logic             adv;
    logic             inc_rise;
    logic             dec_rise;
    logic             ped_rise;

    edge_rise u_inc (.clk(clk), .reset(reset), .d(inc), .rise(inc_rise));
    edge_rise u_dec (.clk(clk), .reset(reset), .d(dec), .rise(dec_rise));

`ifdef TRAFFIC_PED_REQ_EN
    edge_rise u_ped (.clk(clk), .reset(reset), .d(ped_req), .rise(ped_rise));
`else
    assign ped_rise = 1'b0;
`endif

    assign light_a = LIGHT_A_MAP[2*int'(phase) +: 2];
    assign light_b = LIGHT_B_MAP[2*int'(phase) +: 2];

    // Next phase/count: halt overrides countdown; a pedestrian clamp replaces a decrement.
    always_comb begin
        phase_nxt     = phase;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        adv           = 1'b0;
        phase_succ    = (phase == PH_W'(NUM_PHASES - 1)) ? '0 : phase + 1'b1;
        if (halt) begin
            phase_nxt     = '0;
            remaining_nxt = dur[0];
        end else if (tick_en && (remaining <= CNT_W'(1))) begin
            adv           = 1'b1;
            phase_nxt     = phase_succ;
            remaining_nxt = dur[phase_succ];
            done_nxt      = 1'b1;
        end else if (ped_rise && (remaining > CNT_W'(PED_CLAMP))) begin
            remaining_nxt = CNT_W'(PED_CLAMP);
        end else if (tick_en) begin
            remaining_nxt = remaining - CNT_W'(1);
        end
    end

    // Saturating duration edits; simultaneous inc and dec edges cancel.
    always_comb begin
        dur_nxt = dur;
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (cfg_en && (cfg_sel == PH_W'(i)) && (inc_rise ^ dec_rise)) begin
                if (inc_rise) begin
                    dur_nxt[i] = (dur[i] >= CNT_W'(MAX_DUR)) ? CNT_W'(MAX_DUR) : dur[i] + CNT_W'(1);
                end else begin
                    dur_nxt[i] = (dur[i] <= CNT_W'(MIN_DUR)) ? CNT_W'(MIN_DUR) : dur[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            remaining  <= DUR_INIT[CNT_W-1:0];
            phase_done <= 1'b0;
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                dur[i] <= DUR_INIT[i*CNT_W +: CNT_W];
            end
        end else begin
            phase      <= phase_nxt;
            remaining  <= remaining_nxt;
            phase_done <= done_nxt;
            dur        <= dur_nxt;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    // Pending flag holds until the cycle wraps back to phase 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending <= 1'b0;
        end else if (halt || (adv && (phase_succ == '0))) begin
            ped_pending <= 1'b0;
        end else if (ped_rise && !adv) begin
            ped_pending <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer (default parameters).
module tb_traffic_phase_sequencer;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset, tick_en, halt, cfg_en, inc, dec;
    logic [1:0] cfg_sel;
    logic [1:0] phase;
    logic [7:0] remaining;
    logic [1:0] light_a, light_b;
    logic       phase_done;
`ifdef TRAFFIC_PED_REQ_EN
    logic       ped_req, ped_pending;
`endif

    int errors = 0;
    int checks = 0;

    traffic_phase_sequencer dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .halt(halt),
        .cfg_en(cfg_en), .cfg_sel(cfg_sel), .inc(inc), .dec(dec),
        .phase(phase), .remaining(remaining), .light_a(light_a),
        .light_b(light_b), .phase_done(phase_done)
`ifdef TRAFFIC_PED_REQ_EN
        , .ped_req(ped_req), .ped_pending(ped_pending)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick until entry into the target phase; ok=0 if the budget expires.
    task automatic run_to(input logic [1:0] target, output bit ok);
        tick_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (phase == target && phase_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
        checks++; if (remaining !== 8'd3) begin errors++; $display("FAIL reset_rem: got %0d want 3", remaining); end
        checks++; if (phase_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", phase_done); end
        checks++; if (light_a !== L_OFF || light_b !== L_FWD) begin errors++; $display("FAIL reset_lights: got %0d/%0d want 0/2", light_a, light_b); end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        tick_en = 1'b1;
        for (int t = 1; t <= 38; t++) begin
            step();
            if (t == 1) begin
                checks++; if (phase !== 2'd0 || remaining !== 8'd2) begin errors++; $display("FAIL seq_t1: got %0d/%0d want 0/2", phase, remaining); end
            end
            if (t == 3) begin
                checks++; if (phase !== 2'd1 || remaining !== 8'd15 || phase_done !== 1'b1) begin errors++; $display("FAIL seq_t3: got %0d/%0d done=%b want 1/15 done=1", phase, remaining, phase_done); end
                checks++; if (light_a !== L_FWD || light_b !== L_OFF) begin errors++; $display("FAIL seq_lights_p1: got %0d/%0d want 2/0", light_a, light_b); end
            end
            if (t == 4) begin
                checks++; if (remaining !== 8'd14 || phase_done !== 1'b0) begin errors++; $display("FAIL seq_t4: got %0d done=%b want 14 done=0", remaining, phase_done); end
            end
            if (t == 18) begin
                checks++; if (phase !== 2'd2 || remaining !== 8'd10) begin errors++; $display("FAIL seq_t18: got %0d/%0d want 2/10", phase, remaining); end
            end
            if (t == 38) begin
                checks++; if (phase !== 2'd0 || remaining !== 8'd3 || phase_done !== 1'b1) begin errors++; $display("FAIL seq_wrap: got %0d/%0d done=%b want 0/3 done=1", phase, remaining, phase_done); end
            end
        end
    endtask

    task automatic test_tick_gate();
        logic [7:0] exp_rem;
        exp_rem = 8'd3;
        for (int k = 0; k < 3; k++) begin
            tick_en = 1'b0;
            for (int j = 0; j < 3; j++) begin
                step();
                checks++; if (remaining !== exp_rem || phase_done !== 1'b0) begin errors++; $display("FAIL gate_hold: got %0d done=%b want %0d done=0", remaining, phase_done, exp_rem); end
            end
            tick_en = 1'b1;
            step();
            exp_rem = exp_rem - 8'd1;
        end
        checks++; if (phase !== 2'd1 || remaining !== 8'd15 || phase_done !== 1'b1) begin errors++; $display("FAIL gate_adv: got %0d/%0d done=%b want 1/15 done=1", phase, remaining, phase_done); end
        tick_en = 1'b0;
        step();
        checks++; if (phase_done !== 1'b0 || remaining !== 8'd15) begin errors++; $display("FAIL gate_pulse_width: got done=%b rem=%0d want done=0 rem=15", phase_done, remaining); end
    endtask

    task automatic test_cfg_edit();
        bit ok;
        tick_en = 1'b1;
        step(); step(); step();
        checks++; if (remaining !== 8'd12) begin errors++; $display("FAIL cfg_start: got %0d want 12", remaining); end
        cfg_en = 1'b1; cfg_sel = 2'd1;
        for (int k = 0; k < 3; k++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
        checks++; if (phase !== 2'd1 || remaining !== 8'd6) begin errors++; $display("FAIL cfg_live_rem: got %0d/%0d want 1/6", phase, remaining); end
        cfg_en = 1'b0;
        run_to(2'd1, ok);
        checks++; if (!ok || remaining !== 8'd18) begin errors++; $display("FAIL cfg_load18: ok=%b got %0d want 18", ok, remaining); end
        tick_en = 1'b0;
        cfg_en = 1'b1;
        inc = 1'b1;
        for (int k = 0; k < 10; k++) step();
        inc = 1'b0; cfg_en = 1'b0;
        step();
        run_to(2'd1, ok);
        checks++; if (!ok || remaining !== 8'd19) begin errors++; $display("FAIL cfg_hold_once: ok=%b got %0d want 19", ok, remaining); end
    endtask

    task automatic test_halt();
        bit ok;
        run_to(2'd2, ok);
        step(); step(); step();
        checks++; if (!ok || phase !== 2'd2 || remaining !== 8'd7) begin errors++; $display("FAIL halt_pre: ok=%b got %0d/%0d want 2/7", ok, phase, remaining); end
        halt = 1'b1;
        step();
        checks++; if (phase !== 2'd0 || remaining !== 8'd3 || phase_done !== 1'b0) begin errors++; $display("FAIL halt_force: got %0d/%0d done=%b want 0/3 done=0", phase, remaining, phase_done); end
        step(); step(); step();
        checks++; if (phase !== 2'd0 || remaining !== 8'd3) begin errors++; $display("FAIL halt_frozen: got %0d/%0d want 0/3", phase, remaining); end
        halt = 1'b0;
        step();
        checks++; if (remaining !== 8'd2) begin errors++; $display("FAIL halt_rel1: got %0d want 2", remaining); end
        step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL halt_rel2: got %0d want 1", remaining); end
        step();
        checks++; if (phase !== 2'd1 || remaining !== 8'd19 || phase_done !== 1'b1) begin errors++; $display("FAIL halt_rel_adv: got %0d/%0d done=%b want 1/19 done=1", phase, remaining, phase_done); end
    endtask

    task automatic test_saturate();
        bit ok;
        halt = 1'b1; tick_en = 1'b1; cfg_en = 1'b1; cfg_sel = 2'd0;
        step();
        for (int k = 0; k < 5; k++) begin
            dec = 1'b1; step();
            dec = 1'b0; step();
        end
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL sat_min: got %0d want 1", remaining); end
        inc = 1'b1; dec = 1'b1; step();
        inc = 1'b0; dec = 1'b0; step(); step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL sat_both: got %0d want 1", remaining); end
        inc = 1'b1; step();
        inc = 1'b0; step();
        checks++; if (remaining !== 8'd2) begin errors++; $display("FAIL sat_inc_from_min: got %0d want 2", remaining); end
        inc = 1'b1; step();
        inc = 1'b0; step();
        cfg_sel = 2'd2;
        for (int k = 0; k < 250; k++) begin
            inc = 1'b1; step();
            inc = 1'b0; step();
        end
        halt = 1'b0; cfg_en = 1'b0;
        step();
        checks++; if (remaining !== 8'd2) begin errors++; $display("FAIL sat_dur0_restored: got %0d want 2", remaining); end
        run_to(2'd2, ok);
        checks++; if (!ok || remaining !== 8'd255) begin errors++; $display("FAIL sat_max: ok=%b got %0d want 255", ok, remaining); end
        run_to(2'd3, ok);
        checks++; if (!ok || remaining !== 8'd10) begin errors++; $display("FAIL sat_p3: ok=%b got %0d want 10", ok, remaining); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (phase !== 2'd0 || remaining !== 8'd3 || phase_done !== 1'b0) begin errors++; $display("FAIL rmid_state: got %0d/%0d done=%b want 0/3 done=0", phase, remaining, phase_done); end
        reset = 1'b0;
        run_to(2'd1, ok);
        checks++; if (!ok || remaining !== 8'd15) begin errors++; $display("FAIL rmid_dur1: ok=%b got %0d want 15", ok, remaining); end
        run_to(2'd2, ok);
        checks++; if (!ok || remaining !== 8'd10) begin errors++; $display("FAIL rmid_dur2: ok=%b got %0d want 10", ok, remaining); end
    endtask

`ifdef TRAFFIC_PED_REQ_EN
    task automatic test_ped();
        bit ok;
        run_to(2'd1, ok);
        step(); step(); step();
        checks++; if (!ok || remaining !== 8'd12 || ped_pending !== 1'b0) begin errors++; $display("FAIL ped_pre: ok=%b got %0d pend=%b want 12 pend=0", ok, remaining, ped_pending); end
        ped_req = 1'b1;
        step();
        checks++; if (remaining !== 8'd5 || ped_pending !== 1'b1) begin errors++; $display("FAIL ped_clamp: got %0d pend=%b want 5 pend=1", remaining, ped_pending); end
        ped_req = 1'b0;
        step();
        checks++; if (remaining !== 8'd4) begin errors++; $display("FAIL ped_after: got %0d want 4", remaining); end
    endtask
`endif

    initial begin
        reset = 1'b1; tick_en = 1'b0; halt = 1'b0; cfg_en = 1'b0;
        cfg_sel = 2'd0; inc = 1'b0; dec = 1'b0;
`ifdef TRAFFIC_PED_REQ_EN
        ped_req = 1'b0;
`endif
        test_reset();
        test_sequence();
        test_tick_gate();
        test_cfg_edit();
        test_halt();
        test_saturate();
        test_reset_mid();
`ifdef TRAFFIC_PED_REQ_EN
        test_ped();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
